// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite compositor.
// Holds the register field encodings, CTRL bit positions, the packed colour
// layout ({r,g,b}, 3 bits each) and the background reset colour.
package sprite_pkg;

  typedef enum logic [2:0] {
    FLD_X     = 3'd0,
    FLD_Y     = 3'd1,
    FLD_W     = 3'd2,
    FLD_H     = 3'd3,
    FLD_COLOR = 3'd4,
    FLD_CTRL  = 3'd5
  } field_e;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_SHAPE_BIT = 1;
  localparam int unsigned CTRL_W         = 2;
  localparam int unsigned COLOR_W        = 9;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam rgb_t BG_RESET = '{r: 3'b111, g: 3'b000, b: 3'b000};

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite hit test, two pipeline stages.
//   Stage 1 (registered here): |dx|, |dy|, rectangle hit, and a snapshot of the
//     sprite's radius / enable / shape so a commit cannot disturb a pixel in flight.
//   Stage 2 (combinational out of the stage-1 registers; the top registers the
//     resulting colour): circle test dx^2+dy^2 < r^2 and final hit select.
// Ports:
//   clk, rst            clock, async active-low reset
//   pix_x, pix_y        scan coordinate entering stage 1
//   spr_x, spr_y        active sprite centre
//   spr_w, spr_h        half-width / radius, half-height
//   spr_ctrl            {shape, enable}
//   hit                 stage-2 hit for the pixel held in stage 1
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [X_W-1:0]    pix_x,
  input  logic [Y_W-1:0]    pix_y,
  input  logic [X_W-1:0]    spr_x,
  input  logic [Y_W-1:0]    spr_y,
  input  logic [X_W-1:0]    spr_w,
  input  logic [Y_W-1:0]    spr_h,
  input  logic [CTRL_W-1:0] spr_ctrl,
  output logic              hit
);

  localparam int unsigned SQ_W = 2 * X_W + 1;

  logic signed [X_W:0] diff_x;
  logic signed [Y_W:0] diff_y;
  logic [X_W-1:0]      abs_x;
  logic [Y_W-1:0]      abs_y;
  logic                rect_hit;

  // One extra bit keeps the signed difference exact, so coordinates never wrap.
  always_comb begin
    diff_x   = $signed({1'b0, pix_x}) - $signed({1'b0, spr_x});
    diff_y   = $signed({1'b0, pix_y}) - $signed({1'b0, spr_y});
    abs_x    = X_W'(diff_x[X_W] ? -diff_x : diff_x);
    abs_y    = Y_W'(diff_y[Y_W] ? -diff_y : diff_y);
    rect_hit = (abs_x < spr_w) && (abs_y < spr_h);
  end

  logic [X_W-1:0] s1_dx;
  logic [Y_W-1:0] s1_dy;
  logic [X_W-1:0] s1_w;
  logic           s1_rect;
  logic           s1_en;
  logic           s1_circle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_w      <= '0;
      s1_rect   <= 1'b0;
      s1_en     <= 1'b0;
      s1_circle <= 1'b0;
    end else begin
      s1_dx     <= abs_x;
      s1_dy     <= abs_y;
      s1_w      <= spr_w;
      s1_rect   <= rect_hit;
      s1_en     <= spr_ctrl[CTRL_EN_BIT];
      s1_circle <= spr_ctrl[CTRL_SHAPE_BIT];
    end
  end

  logic [SQ_W-1:0] dist_sq;
  logic [SQ_W-1:0] rad_sq;
  logic            circ_hit;

  always_comb begin
    dist_sq  = SQ_W'(s1_dx) * SQ_W'(s1_dx) + SQ_W'(s1_dy) * SQ_W'(s1_dy);
    rad_sq   = SQ_W'(s1_w) * SQ_W'(s1_w);
    circ_hit = dist_sq < rad_sq;
    hit      = s1_en && (s1_circle ? circ_hit : s1_rect);
  end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: double-buffered sprite register file, per-sprite hit
// units and a lowest-index-wins priority mux producing 9-bit RGB, 2-cycle latency.
// Ports:
//   clk, rst                    clock, async active-low reset
//   wr_en/wr_sprite/wr_field/wr_data  CPU writes into the shadow set
//                               (wr_sprite == NUM_SPRITES selects globals)
//   commit                      copies shadow set to active set
//   pix_valid, pix_x, pix_y     pixel request
//   out_valid, ored/ogreen/oblue  result, held while out_valid is low
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 9,
  parameter int unsigned SPR_ID_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SPR_ID_W-1:0] wr_sprite,
  input  logic [2:0]          wr_field,
  input  logic [X_W-1:0]      wr_data,
  input  logic                commit,
  input  logic                pix_valid,
  input  logic [X_W-1:0]      pix_x,
  input  logic [Y_W-1:0]      pix_y,
  output logic                out_valid,
  output logic [2:0]          ored,
  output logic [2:0]          ogreen,
  output logic [2:0]          oblue
);

  logic [X_W-1:0]     sh_x     [NUM_SPRITES];
  logic [Y_W-1:0]     sh_y     [NUM_SPRITES];
  logic [X_W-1:0]     sh_w     [NUM_SPRITES];
  logic [Y_W-1:0]     sh_h     [NUM_SPRITES];
  logic [COLOR_W-1:0] sh_color [NUM_SPRITES];
  logic [CTRL_W-1:0]  sh_ctrl  [NUM_SPRITES];
  logic [COLOR_W-1:0] sh_bg;

  logic [X_W-1:0]     act_x     [NUM_SPRITES];
  logic [Y_W-1:0]     act_y     [NUM_SPRITES];
  logic [X_W-1:0]     act_w     [NUM_SPRITES];
  logic [Y_W-1:0]     act_h     [NUM_SPRITES];
  logic [COLOR_W-1:0] act_color [NUM_SPRITES];
  logic [CTRL_W-1:0]  act_ctrl  [NUM_SPRITES];
  logic [COLOR_W-1:0] act_bg;

  // Shadow writes and commit share one block: the commit copy reads the
  // shadow value from before this cycle's write, so a same-cycle write
  // waits for the next commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]      <= '0;
        sh_y[i]      <= '0;
        sh_w[i]      <= '0;
        sh_h[i]      <= '0;
        sh_color[i]  <= '0;
        sh_ctrl[i]   <= '0;
        act_x[i]     <= '0;
        act_y[i]     <= '0;
        act_w[i]     <= '0;
        act_h[i]     <= '0;
        act_color[i] <= '0;
        act_ctrl[i]  <= '0;
      end
      sh_bg  <= BG_RESET;
      act_bg <= BG_RESET;
    end else begin
      if (commit) begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          act_x[i]     <= sh_x[i];
          act_y[i]     <= sh_y[i];
          act_w[i]     <= sh_w[i];
          act_h[i]     <= sh_h[i];
          act_color[i] <= sh_color[i];
          act_ctrl[i]  <= sh_ctrl[i];
        end
        act_bg <= sh_bg;
      end
      if (wr_en) begin
        if (wr_sprite == SPR_ID_W'(NUM_SPRITES)) begin
          if (wr_field == FLD_COLOR) sh_bg <= wr_data[COLOR_W-1:0];
        end else begin
          for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (wr_sprite == SPR_ID_W'(i)) begin
              case (wr_field)
                FLD_X:     sh_x[i]     <= wr_data;
                FLD_Y:     sh_y[i]     <= wr_data[Y_W-1:0];
                FLD_W:     sh_w[i]     <= wr_data;
                FLD_H:     sh_h[i]     <= wr_data[Y_W-1:0];
                FLD_COLOR: sh_color[i] <= wr_data[COLOR_W-1:0];
                FLD_CTRL:  sh_ctrl[i]  <= wr_data[CTRL_W-1:0];
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  logic [NUM_SPRITES-1:0] hits;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_unit #(
      .X_W (X_W),
      .Y_W (Y_W)
    ) u_hit (
      .clk      (clk),
      .rst      (rst),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .spr_x    (act_x[g]),
      .spr_y    (act_y[g]),
      .spr_w    (act_w[g]),
      .spr_h    (act_h[g]),
      .spr_ctrl (act_ctrl[g]),
      .hit      (hits[g])
    );
  end

  // Colours are snapshotted in stage 1 alongside the geometry.
  logic               s1_valid;
  logic [COLOR_W-1:0] s1_color [NUM_SPRITES];
  logic [COLOR_W-1:0] s1_bg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_bg    <= '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) s1_color[i] <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_bg    <= act_bg;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) s1_color[i] <= act_color[i];
    end
  end

  rgb_t sel_rgb;
  logic found;

  always_comb begin
    sel_rgb = rgb_t'(s1_bg);
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (!found && hits[i]) begin
        sel_rgb = rgb_t'(s1_color[i]);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ored      <= '0;
      ogreen    <= '0;
      oblue     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ored   <= sel_rgb.r;
        ogreen <= sel_rgb.g;
        oblue  <= sel_rgb.b;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed, table-driven bench for sprite_compositor.
module tb_sprite_compositor;

  localparam int unsigned NUM_SPRITES = 4;
  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;
  localparam int unsigned SPR_ID_W    = 5;

  localparam logic [8:0] RED   = 9'b111_000_000;
  localparam logic [8:0] GREEN = 9'b000_111_000;
  localparam logic [8:0] BLUE  = 9'b000_000_111;
  localparam logic [8:0] WHITE = 9'b111_111_111;
  localparam logic [8:0] TEAL  = 9'b001_010_101;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                wr_en = 1'b0;
  logic [SPR_ID_W-1:0] wr_sprite = '0;
  logic [2:0]          wr_field = '0;
  logic [X_W-1:0]      wr_data = '0;
  logic                commit = 1'b0;
  logic                pix_valid = 1'b0;
  logic [X_W-1:0]      pix_x = '0;
  logic [Y_W-1:0]      pix_y = '0;
  logic                out_valid;
  logic [2:0]          ored, ogreen, oblue;

  sprite_compositor #(
    .NUM_SPRITES (NUM_SPRITES),
    .X_W         (X_W),
    .Y_W         (Y_W),
    .SPR_ID_W    (SPR_ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sprite (wr_sprite),
    .wr_field  (wr_field),
    .wr_data   (wr_data),
    .commit    (commit),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .out_valid (out_valid),
    .ored      (ored),
    .ogreen    (ogreen),
    .oblue     (oblue)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef enum {OP_WR, OP_COMMIT, OP_PIX} op_e;
  typedef struct {
    op_e         op;
    int unsigned spr;
    int unsigned fld;
    int unsigned data;
    int unsigned x;
    int unsigned y;
    logic [8:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_wr(input int unsigned spr, input int unsigned fld, input int unsigned data);
    vec_t v;
    v.op = OP_WR; v.spr = spr; v.fld = fld; v.data = data;
    v.x = 0; v.y = 0; v.exp = '0; v.name = "wr";
    vecs.push_back(v);
  endtask

  task automatic add_commit();
    vec_t v;
    v.op = OP_COMMIT; v.spr = 0; v.fld = 0; v.data = 0;
    v.x = 0; v.y = 0; v.exp = '0; v.name = "commit";
    vecs.push_back(v);
  endtask

  task automatic add_pix(input int unsigned x, input int unsigned y, input logic [8:0] exp,
                         input string name);
    vec_t v;
    v.op = OP_PIX; v.spr = 0; v.fld = 0; v.data = 0;
    v.x = x; v.y = y; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic do_write(input int unsigned spr, input int unsigned fld,
                          input int unsigned data, input logic with_commit);
    @(negedge clk);
    wr_en     = 1'b1;
    wr_sprite = SPR_ID_W'(spr);
    wr_field  = 3'(fld);
    wr_data   = X_W'(data);
    commit    = with_commit;
    @(negedge clk);
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Pixel presented at one falling edge is due two rising edges later.
  task automatic check_pix(input int unsigned x, input int unsigned y,
                           input logic [8:0] exp, input string name);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x     = X_W'(x);
    pix_y     = Y_W'(y);
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    check({name, ".valid"}, {8'd0, out_valid}, 9'd1);
    check(name, {ored, ogreen, oblue}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sprite 0: rectangle at (320,240), half-size 64x4, blue.
    add_pix(100, 100, RED, "bg_after_reset");
    add_wr(0, 0, 320); add_wr(0, 1, 240); add_wr(0, 2, 64); add_wr(0, 3, 4);
    add_wr(0, 4, BLUE); add_wr(0, 5, 1);
    add_pix(320, 240, RED, "shadow_not_visible");
    add_commit();
    add_pix(383, 243, BLUE, "rect_inside_edge");
    add_pix(384, 240, RED, "rect_x_strict");
    add_pix(320, 244, RED, "rect_y_strict");
    add_pix(257, 237, BLUE, "rect_left_edge");
    // Sprite 1: circle at (200,200), r=10, green.
    add_wr(1, 0, 200); add_wr(1, 1, 200); add_wr(1, 2, 10);
    add_wr(1, 4, GREEN); add_wr(1, 5, 3);
    add_commit();
    add_pix(206, 208, RED, "circ_eq_r2");
    add_pix(206, 207, GREEN, "circ_inside");
    add_pix(190, 200, RED, "circ_on_radius");
    add_pix(200, 200, GREEN, "circ_centre");
    // Sprite 2 overlaps sprite 0, white; lower index wins.
    add_wr(2, 0, 320); add_wr(2, 1, 240); add_wr(2, 2, 8); add_wr(2, 3, 8);
    add_wr(2, 4, WHITE); add_wr(2, 5, 1);
    add_commit();
    add_pix(320, 240, BLUE, "overlap_prio");
    add_wr(0, 5, 0);
    add_commit();
    add_pix(320, 240, WHITE, "overlap_s0_off");
    add_wr(0, 5, 1);
    add_wr(5, 5, 0);          // sprite index out of range: ignored
    add_wr(0, 6, 0);          // field out of range: ignored
    add_wr(4, 0, 0);          // global non-colour field: ignored
    add_commit();
    add_pix(320, 240, BLUE, "ignored_writes");
    add_pix(0, 0, RED, "clip_corner");
    // Write sprite 0 X to 600 without commit.
    add_wr(0, 0, 600);
    add_pix(320, 240, BLUE, "uncommitted_x");
    add_pix(600, 240, RED, "uncommitted_x_new");

    for (int i = 0; i < 4; i++) @(negedge clk);
    check("reset_valid", {8'd0, out_valid}, 9'd0);
    check("reset_rgb", {ored, ogreen, oblue}, 9'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:     do_write(vecs[i].spr, vecs[i].fld, vecs[i].data, 1'b0);
        OP_COMMIT: do_commit();
        default:   check_pix(vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].name);
      endcase
    end

    // Write X=700 and commit in the same cycle: active takes shadow 600.
    do_write(0, 0, 700, 1'b1);
    check_pix(600, 240, BLUE, "samecycle_prev_shadow");
    check_pix(700, 240, RED, "samecycle_write_pending");
    do_commit();
    check_pix(700, 240, BLUE, "next_commit_new_x");
    check_pix(600, 240, RED, "next_commit_old_x");
    check_pix(320, 240, WHITE, "next_commit_s2");

    // Colours hold while out_valid is low.
    check_pix(700, 240, BLUE, "hold_setup");
    @(negedge clk);
    check("hold_valid", {8'd0, out_valid}, 9'd0);
    check("hold_rgb", {ored, ogreen, oblue}, BLUE);

    // Background register write.
    do_write(NUM_SPRITES, 4, TEAL, 1'b0);
    do_commit();
    check_pix(10, 10, TEAL, "bg_write");

    // Back-to-back stream, then asynchronous reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("stream_valid", {8'd0, out_valid}, 9'd1);
        check("stream_rgb", {ored, ogreen, oblue}, (i % 2 == 0) ? BLUE : TEAL);
      end
      pix_valid = 1'b1;
      pix_x     = (i % 2 == 0) ? X_W'(700) : X_W'(10);
      pix_y     = (i % 2 == 0) ? Y_W'(240) : Y_W'(10);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_valid", {8'd0, out_valid}, 9'd0);
    check("rst_async_rgb", {ored, ogreen, oblue}, 9'd0);
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_pix(700, 240, RED, "post_rst_s0_off");
    check_pix(320, 240, RED, "post_rst_s2_off");
    do_commit();
    check_pix(200, 200, RED, "post_rst_shadow_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
